bank: RTL and testbench

BANK -- requirements
Module: bank

---
 rtl/bank.sv | 87 ++++++++
 tb/tb_bank.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bank.sv
// ---------------------------------------------------------------------------
// bank : single-port-address reference-pixel storage bank.
//
// The storage is a D x W register array. A word is written when beg_en and
// Bank_sel are both high. It is read into the ref_ou register when rd_en is
// high, and ref_ou holds its value while rd_en is low. Read and write share
// one address, so a cycle that both reads and writes always addresses the
// same word. That cycle returns the old contents by default.
//
// Optional feature macro: BANK_WRITE_THROUGH_EN
//   When it is defined, a read in the same cycle as a write returns ref_in
//   (the new data) instead of the old contents.
//
// rst_n is active-high and asynchronous. The codebase names it this way even
// though the polarity is positive. It clears ref_ou and every memory word
// immediately.
// ---------------------------------------------------------------------------
module bank #(
    parameter int PIXEL    = 8,
    parameter int WORD_PIX = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        beg_en,
    input  logic [WORD_PIX*PIXEL-1:0]   ref_in,
    input  logic                        Bank_sel,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        rd_en,
    output logic [WORD_PIX*PIXEL-1:0]   ref_ou
);

    localparam int W = WORD_PIX * PIXEL;
    localparam int D = 1 << ADDR_W;

    logic [W-1:0] mem_q [D];
    logic [W-1:0] ref_ou_q;
    logic [W-1:0] ref_ou_d;
    logic [W-1:0] rd_data;
    logic         wr_en;

    // Write qualifier: the bank must be selected and loading.
    always_comb begin
        wr_en = beg_en & Bank_sel;
    end

    // Read data source: old contents (read-first), or the incoming word when write-through is enabled.
    always_comb begin
        rd_data = mem_q[address];
`ifdef BANK_WRITE_THROUGH_EN
        if (wr_en) begin
            rd_data = ref_in;
        end
`endif
    end

    // Output register next state: capture on rd_en, otherwise hold.
    always_comb begin
        ref_ou_d = ref_ou_q;
        if (rd_en) begin
            ref_ou_d = rd_data;
        end
    end

    // Storage array: cleared as a whole on reset, one word updated per qualified write.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[address] <= ref_in;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ref_ou_q <= '0;
        end else begin
            ref_ou_q <= ref_ou_d;
        end
    end

    assign ref_ou = ref_ou_q;

endmodule

// File: tb/tb_bank.sv
// ---------------------------------------------------------------------------
// tb_bank : scoreboard bench for bank (default parameters, 64-bit x 128).
// ---------------------------------------------------------------------------
module tb_bank;

    logic        clk;
    logic        rst_n;
    logic        beg_en;
    logic [63:0] ref_in;
    logic        Bank_sel;
    logic [6:0]  address;
    logic        rd_en;
    logic [63:0] ref_ou;

    logic [63:0] mdl [128];
    logic [63:0] exp_q [$];
    logic [63:0] last_exp;
    int          n_tests;
    int          n_fail;

    bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .beg_en   (beg_en),
        .ref_in   (ref_in),
        .Bank_sel (Bank_sel),
        .address  (address),
        .rd_en    (rd_en),
        .ref_ou   (ref_ou)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mdl[i] = '0;
        last_exp = '0;
    endtask

    // One clock of stimulus: drive at negedge, push expectation, compare after the edge.
    task automatic step(input logic we, input logic sel, input logic rd,
                        input logic [6:0] a, input logic [63:0] d, input string tag);
        logic [63:0] e;
        @(negedge clk);
        beg_en   = we;
        Bank_sel = sel;
        rd_en    = rd;
        address  = a;
        ref_in   = d;
        e = last_exp;
        if (rd) begin
            e = mdl[a];
`ifdef BANK_WRITE_THROUGH_EN
            if (we && sel) e = d;
`endif
        end
        if (we && sel) mdl[a] = d;
        last_exp = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag, ref_ou, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [63:0] pat;
        n_tests  = 0;
        n_fail   = 0;
        beg_en   = 1'b0;
        Bank_sel = 1'b0;
        rd_en    = 1'b0;
        address  = '0;
        ref_in   = '0;
        rst_n    = 1'b0;
        model_clear();
        #1 rst_n = 1'b1;
        #2 check("rst_init", ref_ou, 64'h0);
        @(negedge clk);
        rst_n = 1'b0;

        // Same-address read and write held for several cycles.
        for (int i = 0; i < 7; i++) begin
            pat = (i < 3) ? 64'h0F0F0F0F0F0F0F0F :
                  (i < 6) ? 64'h5555555555555555 : 64'h3333333333333333;
            step(1'b1, 1'b1, 1'b1, 7'd0, pat, "rw_same_addr");
        end
        step(1'b0, 1'b0, 1'b1, 7'd0, '0, "rw_same_final");

        // Mid-load reset: ref_ou clears without a clock edge, writes are blocked, the array is wiped.
        @(negedge clk);
        beg_en = 1'b1; Bank_sel = 1'b1; rd_en = 1'b1; address = 7'd1;
        ref_in = 64'hDEADBEEFCAFEF00D;
        #2 rst_n = 1'b1;
        #1 check("rst_async", ref_ou, 64'h0);
        @(posedge clk);
        #1 check("rst_hold", ref_ou, 64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b0;
        beg_en = 1'b0; Bank_sel = 1'b0; rd_en = 1'b0;
        for (int a = 0; a < 128; a++)
            step(1'b0, 1'b0, 1'b1, 7'(a), '0, "rst_clear_rd");

        // Bank_sel gates writes.
        step(1'b1, 1'b0, 1'b0, 7'd5, '1, "sel0_wr");
        step(1'b0, 1'b0, 1'b1, 7'd5, '0, "sel0_rd");
        step(1'b1, 1'b1, 1'b0, 7'd5, '1, "sel1_wr");
        step(1'b0, 1'b0, 1'b1, 7'd5, '0, "sel1_rd");

        // Full-depth fill then reverse readback.
        for (int k = 0; k < 128; k++)
            step(1'b1, 1'b1, 1'b0, 7'(k), 64'(k), "fill_wr");
        for (int k = 127; k >= 0; k--)
            step(1'b0, 1'b0, 1'b1, 7'(k), 64'h0, "fill_rd");

        // Hold while rd_en low, and a write elsewhere does not disturb the held value.
        step(1'b1, 1'b1, 1'b0, 7'd3, 64'hABABABABABABABAB, "hold_wr3");
        step(1'b0, 1'b0, 1'b1, 7'd3, '0, "hold_rd3");
        step(1'b0, 1'b0, 1'b0, 7'd20, '0, "hold_addr_chg");
        step(1'b1, 1'b1, 1'b0, 7'd9, 64'h0123456789ABCDEF, "hold_wr9");
        step(1'b0, 1'b1, 1'b0, 7'd3, 64'h1111111111111111, "hold_noload");
        step(1'b0, 1'b0, 1'b1, 7'd9, '0, "rd9_updated");
        step(1'b0, 1'b0, 1'b1, 7'd3, '0, "rd3_intact");

        // Mixed random traffic over a small address window to force collisions.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 7'($urandom_range(0, 7)), {$urandom, $urandom}, "random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
